dmem_responder: RTL

Data-memory responder for the RISC-V core: the memory-side end of the core's load/store interface. Accepts one request at a time over a valid/ready handshake and decodes the RISC-V `func3` access size (byte/half/word, signed/unsigned). Inserts a configurable number of wait states, then returns aligned, sign- or zero-extended load data with an error flag. Sits between the datapath's load/store port and the data storage array, replacing a zero-latency memory when multi-cycle timing is needed.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_lane_align.sv | 83 ++++++++
 rtl/dmem_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - RISC-V func3 access-size codes
//   - responder FSM state encoding
//   - byte-enable type (one bit per byte lane)
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  typedef logic [3:0] dmem_be_t;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for the responder.
// Ports:
//   func3        in   access size / signedness (RISC-V func3)
//   addr_lo      in   byte offset within the word (addr[1:0])
//   wdata        in   right-justified store data
//   rword        in   full 32-bit word read from the array
//   be           out  byte enables for the store
//   wdata_lanes  out  store data replicated onto every lane it may land in
//   rdata_ext    out  selected lane(s) shifted to bit 0 and extended
//   misalign_err out  misaligned access flag (only with DMEM_MISALIGN_TRAP_EN)
// Without DMEM_MISALIGN_TRAP_EN the offset is forced to natural alignment and
// misalign_err is tied low.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output dmem_be_t    be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext,
  output logic        misalign_err
);

  logic [1:0]  size;
  logic [1:0]  off;
  logic [31:0] shifted;
  logic        sext;

  assign size = func3[1:0];
  assign sext = ~func3[2];

  // Aligned offset: halfword drops bit 0, word drops both bits. When trapping
  // is enabled a misaligned access errors out, so the forced offset is moot.
  always_comb begin
    case (size)
      2'd0:    off = addr_lo;
      2'd1:    off = {addr_lo[1], 1'b0};
      default: off = 2'd0;
    endcase
  end

  assign shifted = rword >> {off, 3'b000};

  // Store data is replicated across lanes; the byte enables pick the target.
  always_comb begin
    be          = '0;
    wdata_lanes = wdata;
    rdata_ext   = '0;
    case (size)
      2'd0: begin
        be          = dmem_be_t'(4'b0001 << off);
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        be          = dmem_be_t'(4'b0011 << off);
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      2'd2: begin
        be          = 4'b1111;
        wdata_lanes = wdata;
        rdata_ext   = rword;
      end
      default: ;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    case (size)
      2'd1:    misalign_err = addr_lo[0];
      2'd2:    misalign_err = |addr_lo;
      default: misalign_err = 1'b0;
    endcase
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the core's load/store port. Accepts one
// request at a time, waits WAIT_CYCLES, performs the access on a local word
// array and returns extended load data plus an error flag.
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready  request handshake
//   req_write, req_addr, req_wdata, req_func3  request payload
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata, rsp_err   response payload
// Build option: DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into
// errors; otherwise the low address bits are forced to alignment.
//
// state | meaning
// IDLE  | ready for a request; latches payload on req_valid
// WAIT  | counting wait states; access performed on the last count
// RESP  | response presented until rsp_ready
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  dmem_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_access;
  logic          accept;

  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_func3;

  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [2:0]  acc_func3;
  logic        acc_err;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [31:0]   rword;

  dmem_be_t    be;
  logic [31:0] wdata_lanes;
  logic [31:0] rdata_ext;
  logic        misalign_err;
  logic        range_bad;
  logic        f3_bad;

  assign req_ready = (state_q == ST_IDLE) & rst;
  assign rsp_valid = (state_q == ST_RESP);
  assign accept    = req_valid & req_ready;

  // With zero wait states the access happens on the accepting edge, so the
  // live request is used while idle; otherwise the latched copy.
  assign acc_write = (state_q == ST_IDLE) ? req_write : lat_write;
  assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : lat_addr;
  assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : lat_wdata;
  assign acc_func3 = (state_q == ST_IDLE) ? req_func3 : lat_func3;

  assign word_idx  = acc_addr[AW+1:2];
  assign rword     = mem[word_idx];
  assign range_bad = !(acc_addr[31:2] < 30'(DEPTH_WORDS));
  assign f3_bad    = acc_write ? (acc_func3 > F3_W)
                               : !(acc_func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign acc_err   = range_bad | f3_bad | misalign_err;

  dmem_lane_align u_lane_align (
    .func3        (acc_func3),
    .addr_lo      (acc_addr[1:0]),
    .wdata        (acc_wdata),
    .rword        (rword),
    .be           (be),
    .wdata_lanes  (wdata_lanes),
    .rdata_ext    (rdata_ext),
    .misalign_err (misalign_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_access = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_d   = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          do_access = 1'b1;
          cnt_d     = '0;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_func3 <= '0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_func3 <= req_func3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (do_access) begin
      rsp_rdata <= (acc_err || acc_write) ? 32'd0 : rdata_ext;
      rsp_err   <= acc_err;
    end
  end

  // Storage array: intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_access && acc_write && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

endmodule
